// File: rtl/multiplexor_entrada.sv
// Input-side port multiplexer for the PicoBlaze: latches up to eight peripheral
// sources, tracks pending/overrun per source, and serves them on in_port.
module multiplexor_entrada #(
   parameter logic [7:0] STATUS_PORT = 8'h08,
   parameter logic [7:0] OVR_PORT    = 8'h09,
   parameter logic [7:0] INT_MASK    = 8'hFF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  port_id,
   input  logic        read_strobe,
   input  logic [63:0] src_data,
   input  logic [7:0]  src_valid,
   output logic [7:0]  in_port,
   output logic        interrupt
);

   logic [7:0] hold [8];
   logic [7:0] pend;
   logic [7:0] ovr;

   logic [7:0] ack_vec;
   logic       ovr_clr;
   logic [7:0] pend_next;
   logic [7:0] ovr_set;
   logic [7:0] ovr_next;
   logic [7:0] rd_mux;

   always_comb begin
      ack_vec = 8'h00;
      if (read_strobe && (port_id[7:3] == 5'd0))
         ack_vec[port_id[2:0]] = 1'b1;
   end

   assign ovr_clr = read_strobe && (port_id == OVR_PORT);

   // A capture in the same cycle as an acknowledge keeps the source pending and
   // does not count as an overrun, since the CPU just consumed the old value.
   always_comb begin
      pend_next = (pend & ~ack_vec) | src_valid;
      ovr_set   = src_valid & pend & ~ack_vec;
      ovr_next  = (ovr_clr ? 8'h00 : ovr) | ovr_set;
   end

   always_comb begin
      rd_mux = 8'h00;
      if (port_id[7:3] == 5'd0)
         rd_mux = hold[port_id[2:0]];
      else if (port_id == STATUS_PORT)
         rd_mux = pend;
      else if (port_id == OVR_PORT)
         rd_mux = ovr;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 8; i++)
            hold[i] <= 8'h00;
         pend      <= 8'h00;
         ovr       <= 8'h00;
         in_port   <= 8'h00;
         interrupt <= 1'b0;
      end else begin
         for (int i = 0; i < 8; i++)
            if (src_valid[i])
               hold[i] <= src_data[8*i +: 8];
         pend      <= pend_next;
         ovr       <= ovr_next;
         in_port   <= rd_mux;
         interrupt <= |(pend_next & INT_MASK);
      end
   end

endmodule

// File: tb/tb_multiplexor_entrada.sv
// Directed bench for multiplexor_entrada; a second instance with a narrowed
// interrupt mask shares the stimulus.
module tb_multiplexor_entrada;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  port_id;
   logic        read_strobe;
   logic [63:0] src_data;
   logic [7:0]  src_valid;
   logic [7:0]  in_port,  in_port_m;
   logic        interrupt, interrupt_m;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   multiplexor_entrada dut (
      .clk(clk), .rst(rst), .port_id(port_id), .read_strobe(read_strobe),
      .src_data(src_data), .src_valid(src_valid),
      .in_port(in_port), .interrupt(interrupt)
   );

   multiplexor_entrada #(.INT_MASK(8'hFE)) dut_m (
      .clk(clk), .rst(rst), .port_id(port_id), .read_strobe(read_strobe),
      .src_data(src_data), .src_valid(src_valid),
      .in_port(in_port_m), .interrupt(interrupt_m)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic idle(input logic [7:0] pid);
      port_id     = pid;
      read_strobe = 1'b0;
      src_valid   = 8'h00;
   endtask

   initial begin
      rst = 1'b1; port_id = 8'h00; read_strobe = 1'b0;
      src_data = 64'h0; src_valid = 8'h00;
      tick(); tick();
      rst = 1'b0;
      check("rst_in_port", in_port, 8'h00);
      check("rst_interrupt", {7'd0, interrupt}, 8'h00);
      idle(8'h08); tick();
      check("rst_status", in_port, 8'h00);

      // single capture, status read, acknowledge
      src_data = 64'h0; src_data[31:24] = 8'hA5; src_valid = 8'h08; tick();
      check("cap3_interrupt", {7'd0, interrupt}, 8'h01);
      idle(8'h08); tick();
      check("cap3_status", in_port, 8'h08);
      port_id = 8'h03; read_strobe = 1'b1; tick();
      check("ack3_data", in_port, 8'hA5);
      check("ack3_interrupt", {7'd0, interrupt}, 8'h00);
      idle(8'h08); tick();
      check("ack3_status", in_port, 8'h00);
      idle(8'h03); tick();
      check("stale3_data", in_port, 8'hA5);

      // overrun on source 5
      src_data = 64'h0; src_data[47:40] = 8'h11; src_valid = 8'h20; tick();
      src_data[47:40] = 8'h22; tick();
      idle(8'h05); tick();
      check("ovr5_data", in_port, 8'h22);
      idle(8'h09); tick();
      check("ovr5_bitmap", in_port, 8'h20);
      read_strobe = 1'b1; tick();
      check("ovr5_clear_read", in_port, 8'h20);
      idle(8'h09); tick();
      check("ovr5_cleared", in_port, 8'h00);
      check("ovr5_interrupt", {7'd0, interrupt}, 8'h01);
      port_id = 8'h05; read_strobe = 1'b1; tick();
      idle(8'h08); tick();
      check("ack5_status", in_port, 8'h00);

      // acknowledge and capture on source 2 in the same cycle
      src_data = 64'h0; src_data[23:16] = 8'h3C; src_valid = 8'h04; tick();
      src_data[23:16] = 8'h7E; port_id = 8'h02; read_strobe = 1'b1; tick();
      check("race2_old_data", in_port, 8'h3C);
      idle(8'h08); tick();
      check("race2_status", in_port, 8'h04);
      idle(8'h02); tick();
      check("race2_data", in_port, 8'h7E);
      idle(8'h09); tick();
      check("race2_ovr", in_port, 8'h00);
      port_id = 8'h02; read_strobe = 1'b1; tick();
      idle(8'h08); tick();
      check("ack2_status", in_port, 8'h00);

      // narrowed interrupt mask ignores source 0
      src_data = 64'h0; src_data[7:0] = 8'h55; src_valid = 8'h01; tick();
      check("mask_int_full", {7'd0, interrupt}, 8'h01);
      check("mask_int_masked", {7'd0, interrupt_m}, 8'h00);
      idle(8'h08); tick();
      check("mask_status", in_port_m, 8'h01);
      check("mask_int_hold", {7'd0, interrupt_m}, 8'h00);
      port_id = 8'h00; read_strobe = 1'b1; tick();
      check("mask_ack_data", in_port, 8'h55);
      idle(8'h08);

      // all sources at once, unmapped read, then reset mid-stream
      src_data = 64'h17161514_13121110; src_valid = 8'hFF; tick();
      idle(8'h08); tick();
      check("all_status", in_port, 8'hFF);
      idle(8'h04); tick();
      check("all_data4", in_port, 8'h14);
      idle(8'h07); tick();
      check("all_data7", in_port, 8'h17);
      port_id = 8'h20; read_strobe = 1'b1; tick();
      check("unmapped_read", in_port, 8'h00);
      idle(8'h08); tick();
      check("unmapped_no_effect", in_port, 8'hFF);
      rst = 1'b1; src_data = 64'h2727272727272727; src_valid = 8'hFF; tick();
      rst = 1'b0; idle(8'h08);
      check("midrst_in_port", in_port, 8'h00);
      check("midrst_interrupt", {7'd0, interrupt}, 8'h00);
      for (int p = 0; p <= 8; p++) begin
         idle(8'(p)); tick();
         check($sformatf("midrst_port%0d", p), in_port, 8'h00);
      end
      check("midrst_interrupt_after", {7'd0, interrupt}, 8'h00);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
